// File: rtl/cp0_timer_unit_pkg.sv
// Shared CP0 constants: register numbers, field bit positions and exception codes.
package cp0_timer_unit_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int SR_IE_BIT      = 0;
  localparam int SR_EXL_BIT     = 1;
  localparam int IM_IP_LSB      = 10;
  localparam int CAUSE_EXC_LSB  = 2;
  localparam int CAUSE_TI_BIT   = 30;
  localparam int CAUSE_BD_BIT   = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer_unit_count_timer.sv
// Count/Compare timer: free-running Count, Compare match raises a sticky TI
// that only a Compare write (or reset) clears.
module cp0_count_timer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic        ti_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    ti_d      = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
    if (count_we_i) count_d = wdata_i;
    // A Compare write beats a match in the same cycle.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign ti_o      = ti_q;
  assign count_o   = count_q;
  assign compare_o = compare_q;

endmodule

// File: rtl/cp0_timer_unit.sv
// M-stage coprocessor 0 with SR/Cause/EPC/PRId and an optional Count/Compare
// timer enabled by `define CP0_COUNT_TIMER_EN; the timer drives the top IRQ line.
module cp0_timer_unit
  import cp0_timer_unit_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h2001_1006,
  parameter int          EXC_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           a1,
  input  logic [4:0]           a2,
  input  logic                 cwe,
  input  logic [31:0]          cwd,
  input  logic [31:0]          pc,
  input  logic                 bd_in,
  input  logic [EXC_W-1:0]     ex_code_in,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 exl_clr,
  output logic                 req,
  output logic [31:0]          epc_out,
  output logic [31:0]          cp0_out
);

  logic [NUM_HWINT-1:0] im_q, im_d, ip_q, ip_eff;
  logic                 exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [EXC_W-1:0]     exc_q, exc_d;
  logic [31:0]          epc_q, epc_d;
  logic                 int_req, ex_req, wr_en;
  logic                 ti;
  logic [31:0]          count, compare;
  logic [31:0]          sr_val, cause_val;

  // A trap in flight discards any mtc0 issued alongside it.
  assign wr_en = cwe & ~req;

`ifdef CP0_COUNT_TIMER_EN
  cp0_count_timer u_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .count_we_i   (wr_en && (a2 == REG_COUNT)),
    .compare_we_i (wr_en && (a2 == REG_COMPARE)),
    .wdata_i      (cwd),
    .ti_o         (ti),
    .count_o      (count),
    .compare_o    (compare)
  );
`else
  assign ti      = 1'b0;
  assign count   = '0;
  assign compare = '0;
`endif

  always_comb begin
    ip_eff              = hwint;
    ip_eff[NUM_HWINT-1] = hwint[NUM_HWINT-1] | ti;
  end

  assign int_req = (|(ip_eff & im_q)) & ~exl_q & ie_q;
  assign ex_req  = (ex_code_in != '0) & ~exl_q;
  assign req     = int_req | ex_req;
  assign epc_out = req ? (bd_in ? pc - 32'd4 : pc) : epc_q;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      exc_d = int_req ? '0 : ex_code_in;
      exl_d = 1'b1;
      epc_d = epc_out;
      bd_d  = bd_in;
    end else begin
      if (wr_en && (a2 == REG_SR)) begin
        im_d  = cwd[IM_IP_LSB +: NUM_HWINT];
        exl_d = cwd[SR_EXL_BIT];
        ie_d  = cwd[SR_IE_BIT];
      end
      if (wr_en && (a2 == REG_EPC)) epc_d = cwd;
      if (exl_clr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
      ip_q  <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
      ip_q  <= hwint;
    end
  end

  always_comb begin
    sr_val                                = '0;
    sr_val[IM_IP_LSB +: NUM_HWINT]        = im_q;
    sr_val[SR_EXL_BIT]                    = exl_q;
    sr_val[SR_IE_BIT]                     = ie_q;
    cause_val                             = '0;
    cause_val[CAUSE_BD_BIT]               = bd_q;
    cause_val[CAUSE_TI_BIT]               = ti;
    cause_val[IM_IP_LSB +: NUM_HWINT]     = ip_q;
    cause_val[CAUSE_EXC_LSB +: EXC_W]     = exc_q;
  end

  always_comb begin
    case (a1)
      REG_SR:      cp0_out = sr_val;
      REG_CAUSE:   cp0_out = cause_val;
      REG_EPC:     cp0_out = epc_out;
      REG_PRID:    cp0_out = PRID_VAL;
      REG_COUNT:   cp0_out = count;
      REG_COMPARE: cp0_out = compare;
      default:     cp0_out = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Directed bench for cp0_timer_unit: drivers queue expected values, a negedge
// monitor pops and compares them against the selected DUT output.
module tb_cp0_timer_unit;

  localparam logic [31:0] PRID = 32'h2001_1006;
  localparam logic [31:0] ALL  = 32'hFFFF_FFFF;
  localparam int SEL_CP0 = 0;
  localparam int SEL_REQ = 1;
  localparam int SEL_EPC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2;
  logic        cwe;
  logic [31:0] cwd, pc;
  logic        bd_in;
  logic [4:0]  ex_code_in;
  logic [5:0]  hwint;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out, cp0_out;

  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  cp0_timer_unit dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .cwe(cwe), .cwd(cwd),
    .pc(pc), .bd_in(bd_in), .ex_code_in(ex_code_in), .hwint(hwint),
    .exl_clr(exl_clr), .req(req), .epc_out(epc_out), .cp0_out(cp0_out)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int sel, input logic [31:0] mask,
                          input logic [31:0] val, input string name);
    sel_q.push_back(sel);
    mask_q.push_back(mask);
    exp_q.push_back(val & mask);
    name_q.push_back(name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cwe = 1'b0; exl_clr = 1'b0; ex_code_in = '0; hwint = '0; bd_in = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] mask,
                    input logic [31:0] val, input string name);
    a1 = addr;
    push_exp(SEL_CP0, mask, val, name);
    tick();
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    a2 = addr; cwd = data; cwe = 1'b1;
    tick();
    cwe = 1'b0;
  endtask

  // Monitor: every queued expectation is checked at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, m, obs;
      int          s;
      string       nm;
      e  = exp_q.pop_front();
      m  = mask_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      case (s)
        SEL_REQ: obs = {31'b0, req};
        SEL_EPC: obs = epc_out;
        default: obs = cp0_out;
      endcase
      n_checks++;
      if ((obs & m) !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, obs & m, e);
      end
    end
  end

  initial begin
    reset = 1'b1; a1 = '0; a2 = '0; cwd = '0; pc = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    push_exp(SEL_REQ, ALL, 32'd0, "req_reset");
    rd(5'd12, ALL, 32'd0, "sr_reset");
    rd(5'd13, 32'hC000_FC7C, 32'd0, "cause_reset");
    rd(5'd14, ALL, 32'd0, "epc_reset");
    rd(5'd15, ALL, PRID, "prid");

    // Interrupt beats simultaneous exception; BD adjusts EPC
    wr(5'd12, 32'h0000_0401);
    rd(5'd12, ALL, 32'h0000_0401, "sr_write");
    hwint = 6'h01; pc = 32'h3010; bd_in = 1'b1; ex_code_in = 5'd12;
    push_exp(SEL_REQ, ALL, 32'd1, "int_req");
    push_exp(SEL_EPC, ALL, 32'h300C, "int_epc_bd");
    tick();
    idle();
    push_exp(SEL_REQ, ALL, 32'd0, "req_after_int");
    rd(5'd13, 32'hC000_007C, 32'h8000_0000, "cause_int");
    rd(5'd12, ALL, 32'h0000_0403, "sr_exl_set");
    rd(5'd14, ALL, 32'h300C, "epc_int");
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    rd(5'd12, ALL, 32'h0000_0401, "eret_clears_exl");

    // Exception with IE=0; eret in the same cycle loses to req
    wr(5'd12, 32'd0);
    ex_code_in = 5'd4; pc = 32'h3004; exl_clr = 1'b1;
    push_exp(SEL_REQ, ALL, 32'd1, "adel_req");
    push_exp(SEL_EPC, ALL, 32'h3004, "adel_epc_out");
    tick();
    idle();
    rd(5'd12, ALL, 32'h0000_0002, "exl_wins_over_eret");
    rd(5'd13, 32'hC000_007C, 32'h10, "cause_adel");
    rd(5'd14, ALL, 32'h3004, "epc_adel");
    ex_code_in = 5'd10;
    push_exp(SEL_REQ, ALL, 32'd0, "exl_blocks_req");
    tick();
    idle();
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;

    // mtc0 EPC alongside a trap is discarded
    ex_code_in = 5'd5; pc = 32'h4000; a2 = 5'd14; cwd = 32'h1234; cwe = 1'b1;
    push_exp(SEL_REQ, ALL, 32'd1, "ades_req");
    tick();
    idle();
    rd(5'd14, ALL, 32'h4000, "epc_not_mtc0");
    rd(5'd13, 32'hC000_007C, 32'h14, "cause_ades");

    // Read-only and unmapped registers
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'hC000_007C, 32'h14, "cause_readonly");
    wr(5'd15, 32'd0);
    rd(5'd15, ALL, PRID, "prid_readonly");
    wr(5'd20, 32'hDEAD_BEEF);
    rd(5'd20, ALL, 32'd0, "unmapped_read");

    // Reset mid-operation overrides trap and write
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    wr(5'd12, 32'h0000_0401);
    reset = 1'b1; ex_code_in = 5'd4; pc = 32'h5000;
    a2 = 5'd14; cwd = 32'hABCD; cwe = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    push_exp(SEL_REQ, ALL, 32'd0, "req_after_reset");
    rd(5'd12, ALL, 32'd0, "sr_after_reset");
    rd(5'd14, ALL, 32'd0, "epc_after_reset");

`ifdef CP0_COUNT_TIMER_EN
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    for (int c = 0; c < 6; c++) begin
      a1 = 5'd9;
      push_exp(SEL_CP0, ALL, 32'(c), "count_run");
      push_exp(SEL_REQ, ALL, 32'd0, "timer_no_req_yet");
      tick();
    end
    push_exp(SEL_REQ, ALL, 32'd1, "timer_req");
    tick();
    rd(5'd13, 32'h4000_007C, 32'h4000_0000, "ti_set");
    rd(5'd11, ALL, 32'd5, "compare_read");
    wr(5'd11, 32'd100);
    rd(5'd13, 32'h4000_0000, 32'd0, "ti_cleared");
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, ALL, 32'hFFFF_FFFF, "count_max");
    rd(5'd9, ALL, 32'd0, "count_wrap");
`else
    wr(5'd9, 32'h1234);
    wr(5'd11, 32'd7);
    rd(5'd9, ALL, 32'd0, "count_absent");
    rd(5'd11, ALL, 32'd0, "compare_absent");
    wr(5'd12, 32'h0000_8001);
    push_exp(SEL_REQ, ALL, 32'd0, "no_timer_irq");
    rd(5'd13, 32'h4000_0000, 32'd0, "ti_zero");
`endif

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
